// File: rtl/frame_tx_100m.sv
// Transmit framer/serializer: 32-bit words -> 56-bit {SYNC, CNT, DATA, CRC8} frames, sent MSB first.
// Optional macro FRAME_TX_CRC_INJECT_EN adds crc_err_inject to send a deliberately corrupted CRC byte.
module frame_tx_100m #(
    parameter int unsigned BIT_DIV   = 4,
    parameter logic [7:0]  SYNC_WORD = 8'hAA
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_in_valid,
`ifdef FRAME_TX_CRC_INJECT_EN
    input  logic        crc_err_inject,
`endif
    output logic        data_in_ready,
    output logic        bit_out,
    output logic        bit_valid,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic {ST_IDLE, ST_SHIFT} state_t;

    localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);
    localparam logic [5:0] LAST_BIT = 6'd55;

    // CRC-8, poly 0x07, init 0, MSB first, no reflection, no final XOR
    function automatic logic [7:0] crc8(input logic [47:0] d);
        logic [7:0]  c;
        logic [47:0] s;
        logic        fb;
        c = '0;
        s = d;
        for (int unsigned i = 0; i < 48; i++) begin
            fb = c[7] ^ s[47];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            s  = s << 1;
        end
        return c;
    endfunction

    state_t      state_q, state_d;
    logic [55:0] frame_q, frame_d;
    logic [5:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        bit_out_q, bit_out_d;
    logic        bit_valid_q, bit_valid_d;
    logic        frame_done_q, frame_done_d;

    logic [7:0]  crc_mask;
    logic [47:0] header;
    logic [55:0] frame_new;
    logic        last_period;
    logic        accept;

`ifdef FRAME_TX_CRC_INJECT_EN
    assign crc_mask = crc_err_inject ? 8'hFF : 8'h00;
`else
    assign crc_mask = '0;
`endif

    assign header    = {SYNC_WORD, cnt_q, data_in};
    assign frame_new = {header, crc8(header) ^ crc_mask};

    always_comb begin
        state_d       = state_q;
        frame_d       = frame_q;
        bit_idx_d     = bit_idx_q;
        div_d         = div_q;
        cnt_d         = cnt_q;
        bit_out_d     = bit_out_q;
        bit_valid_d   = 1'b0;
        frame_done_d  = 1'b0;

        // Ready reopens in the final cycle of bit 55 so the next frame follows with no gap
        last_period   = (state_q == ST_SHIFT) && (bit_idx_q == LAST_BIT) && (div_q == DIV_LAST);
        data_in_ready = !rst && ((state_q == ST_IDLE) || last_period);
        accept        = data_in_valid && data_in_ready;

        case (state_q)
            ST_IDLE: ;
            ST_SHIFT: begin
                if (div_q != DIV_LAST) begin
                    div_d = div_q + 8'd1;
                end else if (bit_idx_q != LAST_BIT) begin
                    div_d        = '0;
                    bit_idx_d    = bit_idx_q + 6'd1;
                    frame_d      = frame_q << 1;
                    bit_out_d    = frame_q[54];
                    bit_valid_d  = 1'b1;
                    frame_done_d = (bit_idx_q == LAST_BIT - 6'd1);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d     = ST_SHIFT;
            frame_d     = frame_new;
            bit_out_d   = frame_new[55];
            bit_valid_d = 1'b1;
            bit_idx_d   = '0;
            div_d       = '0;
            cnt_d       = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            frame_q      <= '0;
            bit_idx_q    <= '0;
            div_q        <= '0;
            cnt_q        <= '0;
            bit_out_q    <= 1'b0;
            bit_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            frame_q      <= frame_d;
            bit_idx_q    <= bit_idx_d;
            div_q        <= div_d;
            cnt_q        <= cnt_d;
            bit_out_q    <= bit_out_d;
            bit_valid_q  <= bit_valid_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign bit_out    = bit_out_q;
    assign bit_valid  = bit_valid_q;
    assign frame_done = frame_done_q;
    assign busy       = (state_q == ST_SHIFT);

endmodule

// File: tb/tb_frame_tx_100m.sv
// Directed bench for frame_tx_100m: one BIT_DIV=4 instance and one BIT_DIV=1 instance.
module tb_frame_tx_100m;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic        in_valid;
    logic [31:0] in_data;
    logic        v4, v1;
    logic        rdy4, bo4, bv4, busy4, fd4;
    logic        rdy1, bo1, bv1, busy1, fd1;
    logic        m_ready, m_bo, m_bv, m_busy, m_fd;

    int unsigned passed = 0;
    int unsigned failed = 0;
    int unsigned total  = 0;

    always #5 clk = ~clk;

    assign v4 = in_valid & ~sel;
    assign v1 = in_valid & sel;

    always_comb begin
        m_ready = sel ? rdy1  : rdy4;
        m_bo    = sel ? bo1   : bo4;
        m_bv    = sel ? bv1   : bv4;
        m_busy  = sel ? busy1 : busy4;
        m_fd    = sel ? fd1   : fd4;
    end

    frame_tx_100m #(.BIT_DIV(4), .SYNC_WORD(8'hAA)) dut4 (
        .clk_sys(clk), .rst(rst), .data_in(in_data), .data_in_valid(v4),
        .data_in_ready(rdy4), .bit_out(bo4), .bit_valid(bv4), .busy(busy4), .frame_done(fd4)
    );

    frame_tx_100m #(.BIT_DIV(1), .SYNC_WORD(8'hAA)) dut1 (
        .clk_sys(clk), .rst(rst), .data_in(in_data), .data_in_valid(v1),
        .data_in_ready(rdy1), .bit_out(bo1), .bit_valid(bv1), .busy(busy1), .frame_done(fd1)
    );

    // Remainder of {h, 8'h00} divided by x^8+x^2+x+1 (long division)
    function automatic logic [7:0] model_crc(input logic [47:0] h);
        logic [55:0] r;
        r = {h, 8'h00};
        for (int i = 0; i < 48; i++) begin
            if (r[55]) r[55:47] = r[55:47] ^ 9'h107;
            r = r << 1;
        end
        return r[55:48];
    endfunction

    function automatic logic [55:0] expf(input logic [7:0] c, input logic [31:0] d);
        logic [47:0] h;
        h = {8'hAA, c, d};
        return {h, model_crc(h)};
    endfunction

    function automatic logic [31:0] pat(input int unsigned n);
        return 32'(32'h9E3779B9 * (n + 1));
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] d);
        int unsigned n;
        n        = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (m_ready !== 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("ready_wait", 64'(m_ready), 64'd1);
        @(posedge clk); #1;
    endtask

    // Entered 1 cycle after the accept edge; leaves in the final cycle of bit 55
    task automatic capture(input int unsigned div, input logic [55:0] exp_frame,
                           input bit has_next, input logic [31:0] nxt);
        logic [55:0] rx;
        logic        cur;
        logic        rdy_end;
        int unsigned bad_strobe, bad_done, bad_busy;
        rx = '0; cur = 1'b0; rdy_end = 1'b0;
        bad_strobe = 0; bad_done = 0; bad_busy = 0;
        in_valid = has_next;
        in_data  = has_next ? nxt : 32'hDEAD0000;
        for (int unsigned b = 0; b < 56; b++) begin
            for (int unsigned k = 0; k < div; k++) begin
                if (k == 0) begin
                    rx  = {rx[54:0], m_bo};
                    cur = m_bo;
                end else if (m_bo !== cur) bad_strobe++;
                if (m_bv !== (k == 0)) bad_strobe++;
                if (m_fd !== (k == 0 && b == 55)) bad_done++;
                if (m_busy !== 1'b1) bad_busy++;
                if (b == 55 && k == div - 1) rdy_end = m_ready;
                else if (m_ready !== 1'b0) bad_busy++;
                if (!(b == 55 && k == div - 1)) begin
                    @(posedge clk); #1;
                end
            end
        end
        chk("frame_bits", 64'(rx), 64'(exp_frame));
        chk("strobe_timing", 64'(bad_strobe), 64'd0);
        chk("frame_done", 64'(bad_done), 64'd0);
        chk("busy_ready_mid", 64'(bad_busy), 64'd0);
        chk("ready_last_cycle", 64'(rdy_end), 64'd1);
    endtask

    initial begin
        logic [55:0] f;
        int unsigned nstb, cyc;

        rst = 1'b1; sel = 1'b0; in_valid = 1'b0; in_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_bit_out", 64'(bo4), 64'd0);
        chk("rst_bit_valid", 64'(bv4), 64'd0);
        chk("rst_busy", 64'(busy4), 64'd0);
        chk("rst_frame_done", 64'(fd4), 64'd0);
        chk("rst_ready4", 64'(rdy4), 64'd0);
        chk("rst_ready1", 64'(rdy1), 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", 64'(rdy4), 64'd1);

        // Frame 1 with frame 2 held on the input for back-to-back
        offer(32'h12345678);
        capture(4, expf(8'h00, 32'h12345678), 1'b1, 32'h87654321);
        @(posedge clk); #1;
        capture(4, expf(8'h01, 32'h87654321), 1'b0, 32'h0);

        // No word waiting: idle, bit_out holds last bit
        f = expf(8'h01, 32'h87654321);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("idle_bit_valid", 64'(bv4), 64'd0);
            chk("idle_busy", 64'(busy4), 64'd0);
            chk("idle_bit_hold", 64'(bo4), 64'(f[0]));
            chk("idle_ready_hi", 64'(rdy4), 64'd1);
        end

        // Reset at bit 20 of frame CNT=02
        f = expf(8'h02, 32'hCAFEF00D);
        offer(32'hCAFEF00D);
        in_valid = 1'b0;
        nstb = m_bv ? 1 : 0;
        cyc  = 0;
        while (nstb < 21 && cyc < 400) begin
            @(posedge clk); #1;
            cyc++;
            if (m_bv) nstb++;
        end
        chk("bit20_reached", 64'(nstb), 64'd21);
        chk("bit20_value", 64'(bo4), 64'(f[35]));
        rst = 1'b1;
        #1;
        chk("midrst_bit_valid", 64'(bv4), 64'd0);
        chk("midrst_busy", 64'(busy4), 64'd0);
        chk("midrst_ready", 64'(rdy4), 64'd0);
        chk("midrst_bit_out", 64'(bo4), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("postrst_no_strobe", 64'(bv4), 64'd0);
        offer(32'h0BADBEEF);
        capture(4, expf(8'h00, 32'h0BADBEEF), 1'b0, 32'h0);
        @(posedge clk); #1;

        // BIT_DIV=1: 257 back-to-back frames, counter wraps FF -> 00
        sel = 1'b1;
        offer(pat(0));
        for (int unsigned n = 0; n < 257; n++) begin
            capture(1, expf(8'(n), pat(n)), n < 256, pat(n + 1));
            if (n < 256) begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        chk("div1_idle_strobe", 64'(bv1), 64'd0);
        chk("div1_idle_busy", 64'(busy1), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
